// File: rtl/wptr_full.sv
// Write-side pointer and full/level logic of an asynchronous FIFO.
// Optional sticky overflow detection is compiled in with WPTR_FULL_OVF_EN.
module wptr_full #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wen,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;
  logic          full_next;
  logic          afull_next;

  // Synchronized read pointer back to binary for the level subtraction.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  // A write is accepted only while not full; the pointer advances by that.
  assign wen        = winc & ~wfull;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign level_next = wbin_next - rbin_s;

  // Full when the next write pointer has lapped the read pointer exactly once.
  assign full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  assign full_next  = (wgray_next == full_cmp);
  assign afull_next = (level_next >= PW'(AFULL_THRESH)) | full_next;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
    end
  end

`ifdef WPTR_FULL_OVF_EN
  // Sticky overflow: a rejected write wins over a simultaneous clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (wovf_clr) begin
      woverflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = wovf_clr;
  assign woverflow      = 1'b0;
`endif

endmodule
